// File: rtl/send_ctrl_pkg.sv
// rtl/send_ctrl_pkg.sv - shared state encoding for the send button controller
package send_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Unreachable-state target; lets synthesis treat the default arm as don't-care.
  localparam state_e ERR = state_e'(2'bxx);

endpackage

// File: rtl/repeat_timer.sv
// rtl/repeat_timer.sv - auto-repeat hold timer, built only with SEND_CTRL_AUTO_REPEAT_EN
`ifdef SEND_CTRL_AUTO_REPEAT_EN
module repeat_timer #(
  parameter int unsigned CYCLES = 100,
  parameter int unsigned W      = $clog2(CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = (cnt_q == W'(CYCLES - 1));

endmodule
`endif

// File: rtl/send_ctrl.sv
// rtl/send_ctrl.sv - one transmit request per button press, with optional auto-repeat
// Optional feature macro: SEND_CTRL_AUTO_REPEAT_EN
module send_ctrl
  import send_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REPEAT_CYCLES = 50_000_000,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  tx_busy,
  output logic                  tx_send,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [CNT_WIDTH-1:0]  send_count,
  output logic                  active
);

  if (REPEAT_CYCLES < 2) begin : g_repeat_cycles_check
    $error("send_ctrl: REPEAT_CYCLES must be at least 2");
  end

  state_e                state_q;
  logic                  btn_q;
  logic                  tx_send_q;
  logic                  active_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  press;

  assign press = btn & ~btn_q;

`ifdef SEND_CTRL_AUTO_REPEAT_EN
  localparam int unsigned TIMER_W = $clog2(REPEAT_CYCLES);

  logic rpt_done;
  logic rpt_clr;
  logic rpt_en;

  // Timer only runs while held in HOLD; it freezes at terminal count until the transmitter is free.
  assign rpt_clr = (state_q != HOLD) || !btn || (rpt_done && !tx_busy);
  assign rpt_en  = !rpt_done;

  repeat_timer #(
    .CYCLES (REPEAT_CYCLES),
    .W      (TIMER_W)
  ) u_repeat_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (rpt_clr),
    .en    (rpt_en),
    .done  (rpt_done)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      btn_q     <= 1'b0;
      tx_send_q <= 1'b0;
      active_q  <= 1'b0;
      tx_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      btn_q <= btn;
      case (state_q)
        IDLE: begin
          if (press && !tx_busy) begin
            tx_data_q <= data_in;
            state_q   <= SEND;
            tx_send_q <= 1'b1;
            active_q  <= 1'b1;
          end
        end
        SEND: begin
          if (tx_busy) begin
            state_q   <= WAIT;
            tx_send_q <= 1'b0;
          end
        end
        WAIT: begin
          if (!tx_busy) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!btn) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
`ifdef SEND_CTRL_AUTO_REPEAT_EN
          else if (rpt_done && !tx_busy) begin
            tx_data_q <= data_in;
            state_q   <= SEND;
            tx_send_q <= 1'b1;
          end
`endif
        end
        default: state_q <= ERR;
      endcase
    end
  end

  assign tx_send    = tx_send_q;
  assign tx_data    = tx_data_q;
  assign send_count = cnt_q;
  assign active     = active_q;

endmodule

// File: tb/tb_send_ctrl.sv
// tb/tb_send_ctrl.sv - self-checking bench for send_ctrl (honours SEND_CTRL_AUTO_REPEAT_EN)
module tb_send_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn;
  logic [7:0] data_in;
  logic       tx_busy;
  logic       tx_send;
  logic [7:0] tx_data;
  logic [7:0] send_count;
  logic       active;

  logic       tx_busy_m = 1'b0;
  logic       busy_force;
  int         blen = 20;
  int         busy_left = 0;
  int         dly = 0;

  int         n_cmp = 0;
  int         n_err = 0;
  int         sends = 0;
  int         run = 0;
  logic       send_prev = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         blen;
    int         hold;
    int         exp_count;
  } vec_t;
  vec_t vecs[4];

  assign tx_busy = tx_busy_m | busy_force;

  always #5 clk = ~clk;

  send_ctrl #(
    .DATA_WIDTH    (8),
    .REPEAT_CYCLES (100),
    .CNT_WIDTH     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .data_in    (data_in),
    .tx_busy    (tx_busy),
    .tx_send    (tx_send),
    .tx_data    (tx_data),
    .send_count (send_count),
    .active     (active)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transmitter model: accepts 2 cycles after seeing a request, stays busy blen cycles.
  always @(negedge clk) begin
    if (reset) begin
      busy_left  = 0;
      dly        = 0;
      tx_busy_m  = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy_m = 1'b0;
    end else if (tx_send && !tx_busy_m) begin
      if (dly == 2) begin
        tx_busy_m = 1'b1;
        busy_left = blen;
        dly       = 0;
      end else begin
        dly++;
      end
    end
  end

  // Scoreboard: each request start pops the byte expected at capture time.
  always @(negedge clk) begin
    if (tx_send && !send_prev) begin
      sends++;
      run = 1;
      if (exp_q.size() == 0) chk("unexpected_send", 1, 0);
      else chk("tx_data_at_send", tx_data, exp_q.pop_front());
    end else if (tx_send) begin
      run++;
    end else if (send_prev && !reset) begin
      chk("tx_send_width", run, 3);
    end
    send_prev = tx_send;
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (active && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, active, 0);
  endtask

  task automatic press(input logic [7:0] d, input bit expect_send);
    data_in = d;
    if (expect_send) exp_q.push_back(d);
    btn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_cnt;
    int   s0;
    int   n;
    logic bad;
    logic seen;

    vecs[0] = '{data: 8'h3C, blen: 5,  hold: 4, exp_count: 2};
    vecs[1] = '{data: 8'hFF, blen: 1,  hold: 6, exp_count: 3};
    vecs[2] = '{data: 8'h00, blen: 8,  hold: 3, exp_count: 4};
    vecs[3] = '{data: 8'h5A, blen: 30, hold: 2, exp_count: 5};

    reset = 1'b1; btn = 1'b0; data_in = 8'h00; busy_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_send_count", send_count, 0);
    chk("rst_active", active, 0);
    reset = 1'b0;

    repeat (9) @(negedge clk);
    chk("idle_tx_send", tx_send, 0);
    chk("idle_active", active, 0);

    // Basic press with a 20-cycle transmission, tx_data held throughout
    blen = 20;
    press(8'hA5, 1'b1);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (active && tx_data !== 8'hA5) bad = 1'b1;
    end
    btn = 1'b0;
    wait_idle("basic_idle");
    chk("basic_tx_data_stable", bad, 0);
    chk("basic_send_count", send_count, 1);
    chk("basic_sends", sends, 1);
    exp_cnt = 1;

    for (int i = 0; i < 4; i++) begin
      blen = vecs[i].blen;
      press(vecs[i].data, 1'b1);
      repeat (vecs[i].hold) @(negedge clk);
      btn = 1'b0;
      wait_idle("vec_idle");
      chk("vec_send_count", send_count, vecs[i].exp_count);
      exp_cnt = vecs[i].exp_count;
    end

    // Re-presses during WAIT must not queue a second send
    blen = 20;
    s0 = sends;
    press(8'h11, 1'b1);
    n = 0;
    while (!tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_busy_seen", tx_busy, 1);
    btn = 1'b0; repeat (2) @(negedge clk);
    btn = 1'b1; repeat (2) @(negedge clk);
    btn = 1'b0; repeat (2) @(negedge clk);
    btn = 1'b1; repeat (2) @(negedge clk);
    btn = 1'b0;
    wait_idle("wait_pulse_idle");
    exp_cnt++;
    chk("wait_pulse_count", send_count, exp_cnt);
    press(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    btn = 1'b0;
    wait_idle("repress_idle");
    exp_cnt++;
    chk("repress_count", send_count, exp_cnt);
    chk("repress_sends", sends - s0, 2);

    // Press while the transmitter is busy is dropped
    s0 = sends;
    busy_force = 1'b1;
    press(8'h33, 1'b0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (active) seen = 1'b1;
    end
    btn = 1'b0;
    busy_force = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_press_active", seen, 0);
    chk("busy_press_count", send_count, exp_cnt);
    chk("busy_press_sends", sends - s0, 0);

    // Long hold: one send, or three re-sampled sends with auto-repeat
    s0 = sends;
    blen = 20;
`ifdef SEND_CTRL_AUTO_REPEAT_EN
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h78);
    exp_q.push_back(8'h78);
    press(8'h77, 1'b0);
`else
    press(8'h77, 1'b1);
`endif
    repeat (50) @(negedge clk);
    data_in = 8'h78;
    repeat (250) @(negedge clk);
    btn = 1'b0;
    wait_idle("hold_idle");
`ifdef SEND_CTRL_AUTO_REPEAT_EN
    chk("hold_sends", sends - s0, 3);
    exp_cnt += 3;
`else
    chk("hold_sends", sends - s0, 1);
    exp_cnt += 1;
`endif
    chk("hold_count", send_count, exp_cnt);

    // Asynchronous reset in SEND, then a level already high at release is a press
    press(8'h44, 1'b1);
    n = 0;
    while (!tx_send && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_send", tx_send, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_tx_send", tx_send, 0);
    chk("async_rst_active", active, 0);
    chk("async_rst_count", send_count, 0);
    data_in = 8'h55;
    exp_q.push_back(8'h55);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("level_at_release_active", active, 1);
    btn = 1'b0;
    wait_idle("post_reset_idle");
    chk("post_reset_count", send_count, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
